// File: rtl/rom_sync_dp.sv
// rom_sync_dp -- parametrised dual-port synchronous ROM model.
//
// Two independent read ports share one constant table. Each port has a
// registered stage 1 (CE-gated data, per-cycle valid). In READ_MODE=1 there is
// also an OCE-gated output register. Addresses at or above DEPTH read as zero.
//
// Ports (port B mirrors port A):
//   CLK          clock, all state on rising edge
//   RESETN       synchronous active-low reset, priority over CE/OCE
//   CEA / CEB    read enable
//   OCEA / OCEB  output register enable (READ_MODE=1 only)
//   ADA / ADB    read address
//   DOA / DOB    read data
//   DVA / DVB    data valid
// Optional (macro ROM_SYNC_DP_SCAN_EN): XOR-checksum scan engine
//   SCAN_START in, SCAN_BUSY / SCAN_DONE / SCAN_SUM out.

module rom_sync_dp_port #(
  parameter int DATA_WIDTH = 8,
  parameter int READ_MODE  = 0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  ce,
  input  logic                  oce,
  input  logic [DATA_WIDTH-1:0] rd_word,
  output logic [DATA_WIDTH-1:0] dout,
  output logic                  dv
);

  logic [DATA_WIDTH-1:0] d1_q, d1_d;
  logic                  v1_q, v1_d;

  // Data holds when CE is low, but valid is a one-cycle flag.
  always_comb begin
    d1_d = d1_q;
    v1_d = 1'b0;
    if (ce) begin
      d1_d = rd_word;
      v1_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      d1_q <= '0;
      v1_q <= 1'b0;
    end else begin
      d1_q <= d1_d;
      v1_q <= v1_d;
    end
  end

  if (READ_MODE == 1) begin : g_pipe
    logic [DATA_WIDTH-1:0] d2_q, d2_d;
    logic                  v2_q, v2_d;

    // Output register: both data and valid hold while OCE is low.
    always_comb begin
      d2_d = d2_q;
      v2_d = v2_q;
      if (oce) begin
        d2_d = d1_q;
        v2_d = v1_q;
      end
    end

    always_ff @(posedge clk) begin
      if (!rst_n) begin
        d2_q <= '0;
        v2_q <= 1'b0;
      end else begin
        d2_q <= d2_d;
        v2_q <= v2_d;
      end
    end

    assign dout = d2_q;
    assign dv   = v2_q;
  end else begin : g_bypass
    logic unused_oce;
    assign unused_oce = oce;
    assign dout       = d1_q;
    assign dv         = v1_q;
  end

endmodule

module rom_sync_dp #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4,
  parameter int DEPTH      = 16,
  parameter int READ_MODE  = 0,
  parameter logic [DATA_WIDTH*DEPTH-1:0] INIT = '0
) (
  input  logic                  CLK,
  input  logic                  RESETN,
  input  logic                  CEA,
  input  logic                  OCEA,
  input  logic [ADDR_WIDTH-1:0] ADA,
  output logic [DATA_WIDTH-1:0] DOA,
  output logic                  DVA,
  input  logic                  CEB,
  input  logic                  OCEB,
  input  logic [ADDR_WIDTH-1:0] ADB,
  output logic [DATA_WIDTH-1:0] DOB,
  output logic                  DVB
`ifdef ROM_SYNC_DP_SCAN_EN
  ,
  input  logic                  SCAN_START,
  output logic                  SCAN_BUSY,
  output logic                  SCAN_DONE,
  output logic [DATA_WIDTH-1:0] SCAN_SUM
`endif
);

  localparam int NUM_PORTS = 2;
  localparam int ROM_WORDS = 2 ** ADDR_WIDTH;

  // Full address space table; entries past DEPTH are tied to zero so an
  // out-of-range read needs no compare on the read path.
  logic [DATA_WIDTH-1:0] rom [ROM_WORDS];

  for (genvar gi = 0; gi < ROM_WORDS; gi++) begin : g_rom
    if (gi < DEPTH) begin : g_init
      assign rom[gi] = INIT[gi*DATA_WIDTH +: DATA_WIDTH];
    end else begin : g_zero
      assign rom[gi] = '0;
    end
  end

  logic [NUM_PORTS-1:0]                 ce, oce, dv;
  logic [NUM_PORTS-1:0][ADDR_WIDTH-1:0] ad;
  logic [NUM_PORTS-1:0][DATA_WIDTH-1:0] rd, dout;

  assign ce  = {CEB, CEA};
  assign oce = {OCEB, OCEA};
  assign ad  = {ADB, ADA};

  for (genvar gp = 0; gp < NUM_PORTS; gp++) begin : g_port
    assign rd[gp] = rom[ad[gp]];
    rom_sync_dp_port #(
      .DATA_WIDTH (DATA_WIDTH),
      .READ_MODE  (READ_MODE)
    ) u_port (
      .clk     (CLK),
      .rst_n   (RESETN),
      .ce      (ce[gp]),
      .oce     (oce[gp]),
      .rd_word (rd[gp]),
      .dout    (dout[gp]),
      .dv      (dv[gp])
    );
  end

  assign DOA = dout[0];
  assign DVA = dv[0];
  assign DOB = dout[1];
  assign DVB = dv[1];

`ifdef ROM_SYNC_DP_SCAN_EN
  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} scan_state_e;

  localparam logic [ADDR_WIDTH-1:0] SCAN_LAST = ADDR_WIDTH'(DEPTH - 1);

  scan_state_e           state_q, state_d;
  logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0] acc_q, acc_d;
  logic [DATA_WIDTH-1:0] sum_q, sum_d;

  // The scan reads the table directly, so the port registers never see it.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    sum_d   = sum_q;
    unique case (state_q)
      S_IDLE: begin
        if (SCAN_START) begin
          state_d = S_RUN;
          cnt_d   = '0;
          acc_d   = '0;
        end
      end
      S_RUN: begin
        acc_d = acc_q ^ rom[cnt_q];
        if (cnt_q == SCAN_LAST) begin
          // Load the final sum on entry to DONE so it is already valid
          // while SCAN_DONE is high.
          state_d = S_DONE;
          sum_d   = acc_q ^ rom[cnt_q];
        end else begin
          cnt_d = cnt_q + ADDR_WIDTH'(1);
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RESETN) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      acc_q   <= '0;
      sum_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      sum_q   <= sum_d;
    end
  end

  assign SCAN_BUSY = (state_q != S_IDLE);
  assign SCAN_DONE = (state_q == S_DONE);
  assign SCAN_SUM  = sum_q;
`endif

endmodule

// File: tb/tb_rom_sync_dp.sv
// tb_rom_sync_dp -- directed checks of rom_sync_dp in bypass mode, pipeline
// mode and with a short DEPTH (out-of-range reads). All three instances share
// the stimulus; each check names the instance it observes.

module tb_rom_sync_dp;

  localparam logic [127:0] INIT16 = {8'h10, 8'h0F, 8'h0E, 8'h0D, 8'h0C, 8'h0B, 8'h0A, 8'h09,
                                     8'h08, 8'h07, 8'h06, 8'h05, 8'h04, 8'h03, 8'h02, 8'h01};
  localparam logic [95:0]  INIT12 = {8'h0C, 8'h0B, 8'h0A, 8'h09,
                                     8'h08, 8'h07, 8'h06, 8'h05, 8'h04, 8'h03, 8'h02, 8'h01};

  logic       clk = 1'b0;
  logic       rstn, cea, ocea, ceb, oceb;
  logic [3:0] ada, adb;

  logic [7:0] m0_doa, m0_dob, m1_doa, m1_dob, oor_doa, oor_dob;
  logic       m0_dva, m0_dvb, m1_dva, m1_dvb, oor_dva, oor_dvb;

`ifdef ROM_SYNC_DP_SCAN_EN
  logic       scan_start;
  logic       m0_busy, m0_done, m1_busy, m1_done, oor_busy, oor_done;
  logic [7:0] m0_sum, m1_sum, oor_sum;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  rom_sync_dp #(.DATA_WIDTH(8), .ADDR_WIDTH(4), .DEPTH(16), .READ_MODE(0), .INIT(INIT16)) u_m0 (
    .CLK(clk), .RESETN(rstn),
    .CEA(cea), .OCEA(ocea), .ADA(ada), .DOA(m0_doa), .DVA(m0_dva),
    .CEB(ceb), .OCEB(oceb), .ADB(adb), .DOB(m0_dob), .DVB(m0_dvb)
`ifdef ROM_SYNC_DP_SCAN_EN
    , .SCAN_START(scan_start), .SCAN_BUSY(m0_busy), .SCAN_DONE(m0_done), .SCAN_SUM(m0_sum)
`endif
  );

  rom_sync_dp #(.DATA_WIDTH(8), .ADDR_WIDTH(4), .DEPTH(16), .READ_MODE(1), .INIT(INIT16)) u_m1 (
    .CLK(clk), .RESETN(rstn),
    .CEA(cea), .OCEA(ocea), .ADA(ada), .DOA(m1_doa), .DVA(m1_dva),
    .CEB(ceb), .OCEB(oceb), .ADB(adb), .DOB(m1_dob), .DVB(m1_dvb)
`ifdef ROM_SYNC_DP_SCAN_EN
    , .SCAN_START(scan_start), .SCAN_BUSY(m1_busy), .SCAN_DONE(m1_done), .SCAN_SUM(m1_sum)
`endif
  );

  rom_sync_dp #(.DATA_WIDTH(8), .ADDR_WIDTH(4), .DEPTH(12), .READ_MODE(0), .INIT(INIT12)) u_oor (
    .CLK(clk), .RESETN(rstn),
    .CEA(cea), .OCEA(ocea), .ADA(ada), .DOA(oor_doa), .DVA(oor_dva),
    .CEB(ceb), .OCEB(oceb), .ADB(adb), .DOB(oor_dob), .DVB(oor_dvb)
`ifdef ROM_SYNC_DP_SCAN_EN
    , .SCAN_START(scan_start), .SCAN_BUSY(oor_busy), .SCAN_DONE(oor_done), .SCAN_SUM(oor_sum)
`endif
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Inputs change 1 time unit after a rising edge and outputs are sampled there.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rstn = 1'b0; cea = 1'b0; ocea = 1'b0; ceb = 1'b0; oceb = 1'b0;
    ada = 4'd0; adb = 4'd0;
`ifdef ROM_SYNC_DP_SCAN_EN
    scan_start = 1'b0;
`endif
    tick(); tick();

    // Reset state
    chk("rst_m0_doa", m0_doa, 8'h00);
    chk("rst_m0_dva", m0_dva, 1'b0);
    chk("rst_m0_dvb", m0_dvb, 1'b0);
    chk("rst_m1_doa", m1_doa, 8'h00);
    chk("rst_m1_dva", m1_dva, 1'b0);
    chk("rst_m1_dob", m1_dob, 8'h00);

    // Single read, then CE low: data holds, valid drops
    rstn = 1'b1; cea = 1'b1; ocea = 1'b1; ada = 4'd3;
    tick();
    chk("m0_rd3_doa", m0_doa, 8'h04);
    chk("m0_rd3_dva", m0_dva, 1'b1);
    chk("m1_rd3_lat1_dva", m1_dva, 1'b0);
    chk("m0_portb_idle_dvb", m0_dvb, 1'b0);
    cea = 1'b0;
    tick();
    chk("m0_hold_doa", m0_doa, 8'h04);
    chk("m0_hold_dva", m0_dva, 1'b0);
    chk("m1_rd3_lat2_doa", m1_doa, 8'h04);
    chk("m1_rd3_lat2_dva", m1_dva, 1'b1);

    // Pipeline stream 0,1,2 then OCE dropped for one cycle
    cea = 1'b1; ocea = 1'b1; ada = 4'd0;
    tick();
    chk("m1_stream0_dva", m1_dva, 1'b0);
    ada = 4'd1;
    tick();
    chk("m1_stream_doa_01", m1_doa, 8'h01);
    chk("m1_stream_dva_01", m1_dva, 1'b1);
    chk("m0_stream_doa_02", m0_doa, 8'h02);
    ada = 4'd2;
    tick();
    chk("m1_stream_doa_02", m1_doa, 8'h02);
    ada = 4'd3; ocea = 1'b0;
    tick();
    chk("m1_oce_hold_doa", m1_doa, 8'h02);
    chk("m1_oce_hold_dva", m1_dva, 1'b1);
    ada = 4'd4; ocea = 1'b1;
    tick();
    chk("m1_oce_resume_doa", m1_doa, 8'h04);
    chk("m1_oce_resume_dva", m1_dva, 1'b1);

    // Dual port: same address, then different addresses
    cea = 1'b1; ceb = 1'b1; ocea = 1'b1; oceb = 1'b1; ada = 4'd15; adb = 4'd15;
    tick();
    chk("m0_same_doa", m0_doa, 8'h10);
    chk("m0_same_dob", m0_dob, 8'h10);
    chk("m0_same_dvb", m0_dvb, 1'b1);
    ada = 4'd5; adb = 4'd9;
    tick();
    chk("m0_diff_doa", m0_doa, 8'h06);
    chk("m0_diff_dob", m0_dob, 8'h0A);
    chk("m1_same_doa", m1_doa, 8'h10);
    chk("m1_same_dob", m1_dob, 8'h10);
    cea = 1'b0; ceb = 1'b0;
    tick();
    chk("m1_diff_doa", m1_doa, 8'h06);
    chk("m1_diff_dob", m1_dob, 8'h0A);
    chk("m1_diff_dvb", m1_dvb, 1'b1);

    // Out of range on the DEPTH=12 instance
    cea = 1'b1; ada = 4'd11;
    tick();
    chk("oor_last_doa", oor_doa, 8'h0C);
    ada = 4'd12;
    tick();
    chk("oor_12_doa", oor_doa, 8'h00);
    ada = 4'd13;
    tick();
    chk("oor_13_doa", oor_doa, 8'h00);
    chk("oor_13_dva", oor_dva, 1'b1);
    chk("m0_13_doa", m0_doa, 8'h0E);

    // Reset mid-stream
    cea = 1'b1; ocea = 1'b1; ada = 4'd7;
    tick();
    ada = 4'd8;
    tick();
    rstn = 1'b0; ada = 4'd9;
    tick();
    chk("midrst_m0_doa", m0_doa, 8'h00);
    chk("midrst_m0_dva", m0_dva, 1'b0);
    chk("midrst_m1_doa", m1_doa, 8'h00);
    chk("midrst_m1_dva", m1_dva, 1'b0);
    rstn = 1'b1; ada = 4'd10;
    tick();
    chk("rel1_m0_doa", m0_doa, 8'h0B);
    chk("rel1_m1_dva", m1_dva, 1'b0);
    ada = 4'd11;
    tick();
    chk("rel2_m1_doa", m1_doa, 8'h0B);
    chk("rel2_m1_dva", m1_dva, 1'b1);
    cea = 1'b0;

`ifdef ROM_SYNC_DP_SCAN_EN
    begin
      int busy_cyc;
      int done_at;
      int done_cnt;
      busy_cyc = 0; done_at = 0; done_cnt = 0;
      chk("scan_idle_busy", m0_busy, 1'b0);
      scan_start = 1'b1;
      tick();
      scan_start = 1'b0;
      while (m0_busy && busy_cyc < 40) begin
        busy_cyc++;
        if (m0_done) begin
          done_at = busy_cyc;
          done_cnt++;
          chk("scan_sum_at_done", m0_sum, 8'h10);
        end
        tick();
      end
      chk("scan_busy_cycles", busy_cyc, 17);
      chk("scan_done_cycle", done_at, 17);
      chk("scan_done_pulses", done_cnt, 1);
      chk("scan_sum_hold", m0_sum, 8'h10);
      chk("scan_oor_sum", oor_sum, 8'h0C);
      chk("scan_ports_quiet", m0_dva, 1'b0);
      // Reset during RUN
      scan_start = 1'b1;
      tick();
      scan_start = 1'b0;
      tick(); tick();
      chk("scan_run_busy", m0_busy, 1'b1);
      rstn = 1'b0;
      tick();
      rstn = 1'b1;
      chk("scan_rst_busy", m0_busy, 1'b0);
      chk("scan_rst_done", m0_done, 1'b0);
      chk("scan_rst_sum", m0_sum, 8'h00);
    end
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
